// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants for the multi-port register file slice.
//   DEF_XLEN         default data width
//   DEF_NREGS        default number of architectural registers
//   DEF_REG_ADDR_LEN default register address width (clog2 of DEF_NREGS)
//   X0_IDX           index of the hard-wired zero register
package regfile_mp_pkg;

    localparam int DEF_XLEN         = 32;
    localparam int DEF_NREGS        = 32;
    localparam int DEF_REG_ADDR_LEN = $clog2(DEF_NREGS);
    localparam int X0_IDX           = 0;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   iss, iss_addr     issue strobe and destination (sets busy)
//   we0/wa0, we1/wa1  writeback strobes and addresses (clear busy)
//   flush             clears every busy bit, beats issue and writeback
//   busy              registered busy vector, bit 0 always 0
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss,
    input  logic [ADDR_W-1:0] iss_addr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic              flush,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    // Next busy state: flush > issue > writeback clear > hold, x0 never busy.
    always_comb begin
        busy_nxt_s = busy_r;
        busy_nxt_s[X0_IDX] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_nxt_s[r] = 1'b0;
            end else if (iss && (iss_addr == ADDR_W'(r))) begin
                // A new producer supersedes any writeback landing this cycle.
                busy_nxt_s[r] = 1'b1;
            end else if ((we0 && (wa0 == ADDR_W'(r))) || (we1 && (wa1 == ADDR_W'(r)))) begin
                busy_nxt_s[r] = 1'b0;
            end else begin
                busy_nxt_s[r] = busy_r[r];
            end
        end
    end

    // Busy flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with scoreboard.
// x0 reads as zero and is never busy. Port 1 wins a same-address write
// collision. Optional write-through forwarding: define REGFILE_BYPASS_EN.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ra / rd / rbusy    NRD combinational read ports (address, data, busy)
//   we0/wa0/wd0        write port 0 (ALU writeback)
//   we1/wa1/wd1        write port 1 (load writeback)
//   iss / iss_addr     issue strobe and destination register
//   flush              clear all busy bits
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREGS  = DEF_NREGS,
    parameter  int NRD    = 2,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*XLEN-1:0]   rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [XLEN-1:0]       wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [XLEN-1:0]       wd1,
    input  logic                  iss,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush
);

    logic [XLEN-1:0]   regs_r [NREGS];
    logic [NREGS-1:0]  busy_s;
    logic [ADDR_W-1:0] a_s;

    regfile_mp_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss      (iss),
        .iss_addr (iss_addr),
        .we0      (we0),
        .wa0      (wa0),
        .we1      (we1),
        .wa1      (wa1),
        .flush    (flush),
        .busy     (busy_s)
    );

    // Register storage; entry 0 is a constant zero and folds away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
        end else begin
            regs_r[X0_IDX] <= '0;
            for (int r = 1; r < NREGS; r++) begin
                if (we1 && (wa1 == ADDR_W'(r))) begin
                    regs_r[r] <= wd1;
                end else if (we0 && (wa0 == ADDR_W'(r))) begin
                    regs_r[r] <= wd0;
                end else begin
                    regs_r[r] <= regs_r[r];
                end
            end
        end
    end

    // Read muxes, with optional forwarding of this cycle's writes.
    always_comb begin
        rd    = '0;
        rbusy = '0;
        a_s   = '0;
        for (int i = 0; i < NRD; i++) begin
            a_s = ra[i*ADDR_W +: ADDR_W];
            if (a_s == ADDR_W'(X0_IDX)) begin
                rd[i*XLEN +: XLEN] = '0;
                rbusy[i]           = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            // Forwarded data is only stale-free if no newer producer issues now.
            else if (we1 && (wa1 == a_s)) begin
                rd[i*XLEN +: XLEN] = wd1;
                rbusy[i]           = iss && (iss_addr == a_s);
            end else if (we0 && (wa0 == a_s)) begin
                rd[i*XLEN +: XLEN] = wd0;
                rbusy[i]           = iss && (iss_addr == a_s);
            end
`endif
            else begin
                rd[i*XLEN +: XLEN] = regs_r[a_s];
                rbusy[i]           = busy_s[a_s];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NRD*AW-1:0]   ra = '0;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rbusy;
    logic                we0 = 1'b0, we1 = 1'b0, iss = 1'b0, flush = 1'b0;
    logic [AW-1:0]       wa0 = '0, wa1 = '0, iss_addr = '0;
    logic [XLEN-1:0]     wd0 = '0, wd1 = '0;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference state: plain arrays of register values and pending flags.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .iss(iss), .iss_addr(iss_addr), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endfunction

    // What a read of address a must return right now.
    function automatic void model_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d, output logic b);
        d = (a == 0) ? '0 : m_regs[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && ((we1 && wa1 == a) || (we0 && wa0 == a))) begin
            d = (we1 && wa1 == a) ? wd1 : wd0;
            b = iss && (iss_addr == a);
        end
`endif
    endfunction

    // Commit one clock edge: apply rules lowest-priority first so later ones win.
    function automatic void model_edge();
        if (we0 && wa0 != 0) m_regs[wa0] = wd0;
        if (we1 && wa1 != 0) m_regs[wa1] = wd1;
        if (we0) m_busy[wa0] = 1'b0;
        if (we1) m_busy[wa1] = 1'b0;
        if (iss) m_busy[iss_addr] = 1'b1;
        if (flush) for (int r = 0; r < NREGS; r++) m_busy[r] = 1'b0;
        m_busy[0] = 1'b0;
    endfunction

    // Compare every read port against the model mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < NRD; i++) begin
                logic [XLEN-1:0] ed;
                logic            eb;
                model_read(ra[i*AW +: AW], ed, eb);
                check($sformatf("rd%0d", i), rd[i*XLEN +: XLEN], ed);
                check($sformatf("rbusy%0d", i), {31'd0, rbusy[i]}, {31'd0, eb});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        we0 = 1'b0; we1 = 1'b0; iss = 1'b0; flush = 1'b0;
    endtask

    task automatic set_ra(input int p, input logic [AW-1:0] a);
        ra[p*AW +: AW] = a;
        #1;
    endtask

    initial begin
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_en = 1'b1;

        // Reset state.
        set_ra(0, 5'd5); set_ra(1, 5'd31);
        check("reset_rd0", rd[31:0], 32'h0);
        check("reset_rd1", rd[63:32], 32'h0);
        check("reset_busy", {30'd0, rbusy}, 32'd0);

        // x0 guard.
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; tick();
        set_ra(0, 5'd0);
        check("x0_write", rd[31:0], 32'h0);
        iss = 1'b1; iss_addr = 5'd0; tick();
        check("x0_busy", {31'd0, rbusy[0]}, 32'd0);

        // Write collision: port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; tick();
        set_ra(0, 5'd7);
        check("collision", rd[31:0], 32'h22);

        // Scoreboard race: issue beats same-cycle writeback.
        set_ra(0, 5'd3);
        iss = 1'b1; iss_addr = 5'd3; tick();
        check("race_set", {31'd0, rbusy[0]}, 32'd1);
        iss = 1'b1; iss_addr = 5'd3; we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5; tick();
        check("race_hold", {31'd0, rbusy[0]}, 32'd1);
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h33; tick();
        check("race_clear", {31'd0, rbusy[0]}, 32'd0);
        check("race_data", rd[31:0], 32'h33);

        // Flush beats same-cycle issue and leaves data alone.
        iss = 1'b1; iss_addr = 5'd1; tick();
        iss = 1'b1; iss_addr = 5'd2; tick();
        iss = 1'b1; iss_addr = 5'd9; tick();
        set_ra(0, 5'd9);
        check("pre_flush_busy9", {31'd0, rbusy[0]}, 32'd1);
        flush = 1'b1; iss = 1'b1; iss_addr = 5'd4; tick();
        set_ra(0, 5'd1); set_ra(1, 5'd2);
        check("flush_busy_1_2", {30'd0, rbusy}, 32'd0);
        set_ra(0, 5'd9); set_ra(1, 5'd4);
        check("flush_busy_9_4", {30'd0, rbusy}, 32'd0);
        set_ra(0, 5'd7); set_ra(1, 5'd3);
        check("flush_keeps_x7", rd[31:0], 32'h22);
        check("flush_keeps_x3", rd[63:32], 32'h33);

        // Same-cycle read of a register being written by port 1.
        set_ra(1, 5'd8);
        we1 = 1'b1; wa1 = 5'd8; wd1 = 32'hCAFE; #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_now", rd[63:32], 32'hCAFE);
        check("bypass_busy", {31'd0, rbusy[1]}, 32'd0);
`else
        check("nobypass_now", rd[63:32], 32'h0);
`endif
        tick();
        check("bypass_next", rd[63:32], 32'hCAFE);

        // Asynchronous reset mid-operation.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        iss = 1'b1; iss_addr = 5'd5; tick();
        set_ra(0, 5'd5);
        check("pre_reset", rd[31:0], 32'hDEADBEEF);
        check("pre_reset_busy", {31'd0, rbusy[0]}, 32'd1);
        rst = 1'b1; model_clear(); #1;
        check("async_reset_rd", rd[31:0], 32'h0);
        check("async_reset_busy", {31'd0, rbusy[0]}, 32'd0);
        tick();
        rst = 1'b0;
        set_ra(0, 5'd8);
        check("reset_cleared_x8", rd[31:0], 32'h0);

        // Randomised traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            we0 = ($urandom_range(0, 99) < 40);
            we1 = ($urandom_range(0, 99) < 30);
            iss = ($urandom_range(0, 99) < 40);
            flush = ($urandom_range(0, 99) < 3);
            wa0 = AW'($urandom_range(0, 15));
            wa1 = AW'($urandom_range(0, 15));
            iss_addr = AW'($urandom_range(0, 15));
            wd0 = $urandom;
            wd1 = $urandom;
            ra = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
